// File: rtl/wait_state_memory.sv
// Word-wide memory with byte-lane writes, a req/ready handshake with fixed wait states,
// and an optional zeroing sweep after reset.
module wait_state_memory #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 13,
   parameter int unsigned WAIT           = 2,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   be,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ready,
   output logic                  init_done
);

   localparam int unsigned LANES = DATA_W / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {INIT, IDLE, WAITS, RESP} state_t;
   localparam state_t RESET_STATE = CLEAR_ON_RESET ? INIT : IDLE;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state, stateNext;
   logic [CNT_W-1:0]  cnt, cntNext;
   logic [ADDR_W-1:0] ptr, ptrNext;
   logic [ADDR_W-1:0] addrQ, addrNext;
   logic              weQ, weNext;
   logic              readyNext, initDoneNext;
   logic [DATA_W-1:0] rdataNext;
   logic              memWr;
   logic [ADDR_W-1:0] memWrAddr;
   logic [DATA_W-1:0] memWrData;
   logic [LANES-1:0]  memWrBe;

   // State and registered outputs; memory contents are deliberately not reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RESET_STATE;
         cnt       <= '0;
         ptr       <= '0;
         addrQ     <= '0;
         weQ       <= 1'b0;
         ready     <= 1'b0;
         rdata     <= '0;
         init_done <= ~CLEAR_ON_RESET;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         ptr       <= ptrNext;
         addrQ     <= addrNext;
         weQ       <= weNext;
         ready     <= readyNext;
         rdata     <= rdataNext;
         init_done <= initDoneNext;
      end
   end

   // Next state; ready is raised on the edge entering RESP so it is high only in RESP.
   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      ptrNext      = ptr;
      addrNext     = addrQ;
      weNext       = weQ;
      readyNext    = 1'b0;
      initDoneNext = init_done;
      rdataNext    = rdata;
      memWr        = 1'b0;
      memWrAddr    = addr;
      memWrData    = wdata;
      memWrBe      = be;
      case (state)
         INIT: begin
            memWr     = 1'b1;
            memWrAddr = ptr;
            memWrData = '0;
            memWrBe   = '1;
            ptrNext   = ptr + ADDR_W'(1);
            if (&ptr) begin
               stateNext    = IDLE;
               initDoneNext = 1'b1;
            end
         end
         IDLE: begin
            if (req) begin
               addrNext = addr;
               weNext   = we;
               memWr    = we;
               if (WAIT != 0) begin
                  stateNext = WAITS;
                  cntNext   = CNT_W'(WAIT - 1);
               end else begin
                  stateNext = RESP;
                  readyNext = 1'b1;
                  if (!we) rdataNext = mem[addr];
               end
            end
         end
         WAITS: begin
            cntNext = cnt - CNT_W'(1);
            if (cnt == '0) begin
               stateNext = RESP;
               readyNext = 1'b1;
               if (!weQ) rdataNext = mem[addrQ];
            end
         end
         RESP: stateNext = IDLE;
         default: stateNext = RESET_STATE;
      endcase
   end

   // Byte-lane write port, shared by the clear sweep and accepted writes.
   always_ff @(posedge clk) begin
      if (memWr) begin
         for (int i = 0; i < LANES; i++) begin
            if (memWrBe[i]) mem[memWrAddr][8*i +: 8] <= memWrData[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench: four memories with WAIT = index (index 3 has no clear sweep).
module tb_wait_state_memory;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic [3:0]    rst, req, ready, initDone;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [3:0]    be;
   logic [DW-1:0] rdata [4];

   int  checks = 0;
   int  failures = 0;
   time readyT;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : gDut
      wait_state_memory #(
         .DATA_W(DW), .ADDR_W(AW), .WAIT(g), .CLEAR_ON_RESET(g != 3)
      ) u (
         .clk(clk), .rst(rst[g]), .req(req[g]), .we(we), .addr(addr),
         .wdata(wdata), .be(be), .rdata(rdata[g]), .ready(ready[g]),
         .init_done(initDone[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Starts in an IDLE cycle; returns in the IDLE cycle after the ready pulse.
   task automatic access(input int k, input logic w, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] b, output int lat, output logic [31:0] rd);
      req[k] = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(posedge clk); #1;
      req[k] = 1'b0;
      lat = 1;
      while (!ready[k] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = rdata[k];
      readyT = $time;
      @(posedge clk); #1;
      check("ready_one_cycle", 32'(ready[k]), 32'd0);
   endtask

   initial begin
      int          lat, n;
      logic [31:0] rd;
      logic        sawReady;
      time         t0;

      rst = 4'hF; req = '0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      #3 rst = 4'h0;
      #4;
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_rdata2", rdata[2], 32'd0);
      check("rst_init_clear", 32'(initDone[2]), 32'd0);
      check("rst_init_noclear", 32'(initDone[3]), 32'd1);

      // Clear sweep with a write request pulsed during INIT
      @(posedge clk); #1;
      rst = 4'hF;
      n = 0; sawReady = 1'b0;
      while (!initDone[2] && n < 40) begin
         if (n == 3) begin req[2] = 1'b1; we = 1'b1; addr = 4'd7; wdata = 32'hFFFF_FFFF; be = 4'hF; end
         if (n == 6) req[2] = 1'b0;
         @(posedge clk); #1;
         n++;
         sawReady |= ready[2];
      end
      check("sweep_cycles", 32'(n), 32'd16);
      check("init_req_ignored", 32'(sawReady), 32'd0);
      for (int a = 0; a < 16; a++) begin
         access(2, 1'b0, 4'(a), 32'h0, 4'h0, lat, rd);
         check("clear_rd", rd, 32'd0);
      end

      // Write then read, WAIT=2
      access(2, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF, lat, rd);
      check("wr_latency", 32'(lat), 32'd3);
      access(2, 1'b0, 4'd5, 32'h0, 4'h0, lat, rd);
      check("rd_latency", 32'(lat), 32'd3);
      check("rd_deadbeef", rd, 32'hDEAD_BEEF);

      // Byte lanes and be=0 no-op write
      access(2, 1'b1, 4'd9, 32'h1122_3344, 4'hF, lat, rd);
      access(2, 1'b1, 4'd9, 32'hAABB_CCDD, 4'b0101, lat, rd);
      access(2, 1'b0, 4'd9, 32'h0, 4'h0, lat, rd);
      check("lane_merge", rd, 32'h11BB_33DD);
      access(2, 1'b1, 4'd9, 32'hFFFF_FFFF, 4'h0, lat, rd);
      check("be0_latency", 32'(lat), 32'd3);
      check("rdata_hold", rdata[2], 32'h11BB_33DD);
      access(2, 1'b0, 4'd9, 32'h0, 4'h0, lat, rd);
      check("be0_unchanged", rd, 32'h11BB_33DD);

      // Back-to-back alternate write/read, WAIT=0
      for (int i = 0; i < 4; i++) begin
         access(0, 1'b1, 4'd3, 32'h0101_0101 * (i + 1), 4'hF, lat, rd);
         check("b2b_wr_latency", 32'(lat), 32'd1);
         t0 = readyT;
         access(0, 1'b0, 4'd3, 32'h0, 4'h0, lat, rd);
         check("b2b_rd", rd, 32'h0101_0101 * (i + 1));
         check("b2b_period", 32'(readyT - t0), 32'd20);
      end

      // Reset during WAITS, WAIT=3, no clear sweep
      access(3, 1'b1, 4'd2, 32'hCAFE_F00D, 4'hF, lat, rd);
      access(3, 1'b0, 4'd2, 32'h0, 4'h0, lat, rd);
      check("w3_latency", 32'(lat), 32'd4);
      check("w3_rd", rd, 32'hCAFE_F00D);
      req[3] = 1'b1; we = 1'b0; addr = 4'd2;
      @(posedge clk); #1;
      req[3] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst[3] = 1'b0;
      #1;
      check("midrst_ready", 32'(ready[3]), 32'd0);
      check("midrst_rdata", rdata[3], 32'd0);
      @(posedge clk); #1;
      rst[3] = 1'b1;
      sawReady = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         sawReady |= ready[3];
      end
      check("midrst_no_pulse", 32'(sawReady), 32'd0);
      check("noclear_init_done", 32'(initDone[3]), 32'd1);
      access(3, 1'b0, 4'd2, 32'h0, 4'h0, lat, rd);
      check("retained", rd, 32'hCAFE_F00D);

      // Held req through an access, WAIT=1
      access(1, 1'b1, 4'd6, 32'hA5A5_A5A5, 4'hF, lat, rd);
      req[1] = 1'b1; we = 1'b1; addr = 4'd4; wdata = 32'h1234_5678; be = 4'hF;
      @(posedge clk); #1;
      check("held_accept", 32'(ready[1]), 32'd0);
      we = 1'b0; addr = 4'd6; wdata = 32'h5555_5555;
      @(posedge clk); #1;
      check("held_ready1", 32'(ready[1]), 32'd1);
      @(posedge clk); #1;
      check("held_idle", 32'(ready[1]), 32'd0);
      @(posedge clk); #1;
      check("held_waits", 32'(ready[1]), 32'd0);
      @(posedge clk); #1;
      check("held_ready2", 32'(ready[1]), 32'd1);
      check("held_rd6", rdata[1], 32'hA5A5_A5A5);
      req[1] = 1'b0;
      @(posedge clk); #1;
      access(1, 1'b0, 4'd4, 32'h0, 4'h0, lat, rd);
      check("held_wr4", rd, 32'h1234_5678);
      access(1, 1'b0, 4'd6, 32'h0, 4'h0, lat, rd);
      check("held_rd6_again", rd, 32'hA5A5_A5A5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
